// File: rtl/segasys1_sprrom_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : segasys1_sprrom_ctrl_pkg                                      |
// | Purpose  : Shared definitions for the sprite pattern ROM fetch           |
// |            controller: FSM encoding, default byte address width,         |
// |            byte-lane select constants and a byte select helper.          |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package segasys1_sprrom_ctrl_pkg;

  // Default renderer byte address width; word address is one bit narrower.
  localparam int C_SPRROM_AW = 18;

  // Width of the external pattern memory word.
  localparam int C_WORD_W = 16;

  // Byte-lane select: address bit 0 picks the lane (little-endian).
  localparam logic       C_LANE_LO = 1'b0;
  localparam logic       C_LANE_HI = 1'b1;

  // Byte enables driven on MEM_BE.
  localparam logic [1:0] C_BE_LO   = 2'b01;
  localparam logic [1:0] C_BE_HI   = 2'b10;
  localparam logic [1:0] C_BE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIT   = 3'd1,
    ST_FETCH = 3'd2,
    ST_RESP  = 3'd3,
    ST_WRITE = 3'd4
  } sprrom_state_t;

  // Pick the byte addressed by 'lane' out of a memory word.
  function automatic logic [7:0] sel_byte(input logic [C_WORD_W-1:0] word,
                                          input logic                lane);
    return (lane == C_LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/segasys1_sprrom_ctrl_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : segasys1_sprrom_line                                          |
// | Purpose  : Single-word line cache: tag, valid bit and one 16-bit word,   |
// |            with hit compare and a tag-matched invalidate port.           |
// | Ports    : VCLKx8/RESET_N  clock, async active-low reset                 |
// |            fill/fill_ok/fill_tag/fill_data  line load (valid=fill_ok)    |
// |            inval/inval_tag  clear valid when inval_tag matches the tag   |
// |            look_tag -> hit, line_data  lookup result                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module segasys1_sprrom_line
  import segasys1_sprrom_ctrl_pkg::*;
#(
  parameter int WAW = C_SPRROM_AW - 1
) (
  input  logic                VCLKx8,
  input  logic                RESET_N,
  input  logic                fill,
  input  logic                fill_ok,
  input  logic [WAW-1:0]      fill_tag,
  input  logic [C_WORD_W-1:0] fill_data,
  input  logic                inval,
  input  logic [WAW-1:0]      inval_tag,
  input  logic [WAW-1:0]      look_tag,
  output logic                hit,
  output logic [C_WORD_W-1:0] line_data
);

  logic [WAW-1:0]      r_tag;
  logic                r_valid;
  logic [C_WORD_W-1:0] r_data;

  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (fill) begin
      // The controller folds any same-cycle invalidate into fill_ok.
      r_tag   <= fill_tag;
      r_data  <= fill_data;
      r_valid <= fill_ok;
    end else if (inval && (inval_tag == r_tag)) begin
      r_valid <= 1'b0;
    end
  end

  assign hit       = r_valid && (look_tag == r_tag);
  assign line_data = r_data;

endmodule
`default_nettype wire

// File: rtl/segasys1_sprrom_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : segasys1_sprrom_ctrl                                          |
// | Purpose  : Sprite pattern ROM fetch controller and arbiter. Shares the   |
// |            16-bit pattern memory between the renderer (byte reads with   |
// |            req/ack) and the ROM download writer (one-entry buffer,       |
// |            priority over reads).                                         |
// | Ports    : VCLKx8, RESET_N            clock, async active-low reset      |
// |            SPR_REQ/SPR_AD -> SPR_ACK/SPR_DT   renderer byte read         |
// |            DL_WR/DL_AD/DL_DT -> DL_BUSY       download byte write        |
// |            MEM_REQ/WE/AD/WD/BE, MEM_ACK/RD    pattern memory client      |
// | Config   : SEGASYS1_SPRROM_CACHE_EN enables the single-word line cache.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module segasys1_sprrom_ctrl
  import segasys1_sprrom_ctrl_pkg::*;
#(
  parameter int AW = C_SPRROM_AW
) (
  input  logic                VCLKx8,
  input  logic                RESET_N,
  input  logic                SPR_REQ,
  input  logic [AW-1:0]       SPR_AD,
  output logic                SPR_ACK,
  output logic [7:0]          SPR_DT,
  input  logic                DL_WR,
  input  logic [AW-1:0]       DL_AD,
  input  logic [7:0]          DL_DT,
  output logic                DL_BUSY,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [AW-2:0]       MEM_AD,
  output logic [C_WORD_W-1:0] MEM_WD,
  output logic [1:0]          MEM_BE,
  input  logic                MEM_ACK,
  input  logic [C_WORD_W-1:0] MEM_RD
);

  sprrom_state_t r_state, w_state_nxt;

  logic                r_dl_busy;
  logic [AW-1:0]       r_dl_ad;
  logic [7:0]          r_dl_dt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [AW-2:0]       r_mem_ad;
  logic [C_WORD_W-1:0] r_mem_wd;
  logic [1:0]          r_mem_be;
  logic                r_fetch_lane;
  logic [7:0]          r_spr_dt;

  logic                w_dl_accept;
  logic                w_dl_pend;
  logic [AW-1:0]       w_dl_pend_ad;
  logic [7:0]          w_dl_pend_dt;
  logic                w_hit;
  logic [C_WORD_W-1:0] w_line_data;
  logic                w_spr_ack;
  logic                w_go_hit;
  logic                w_go_fetch;
  logic                w_go_write;
  logic                w_fetch_done;
  logic                w_write_done;

  // A write arriving while the buffer is full is dropped.
  assign w_dl_accept  = DL_WR && !r_dl_busy;
  // A write captured this very cycle already wins arbitration in IDLE.
  assign w_dl_pend    = r_dl_busy || w_dl_accept;
  assign w_dl_pend_ad = r_dl_busy ? r_dl_ad : DL_AD;
  assign w_dl_pend_dt = r_dl_busy ? r_dl_dt : DL_DT;

`ifdef SEGASYS1_SPRROM_CACHE_EN
  logic w_fill_ok;

  // A download aimed at the word being fetched lands in memory after the
  // read, so the returned data is already stale: fill without validating.
  assign w_fill_ok = !((r_dl_busy   && (r_dl_ad[AW-1:1] == r_mem_ad)) ||
                       (w_dl_accept && (DL_AD[AW-1:1]   == r_mem_ad)));

  segasys1_sprrom_line #(
    .WAW (AW-1)
  ) u_line (
    .VCLKx8    (VCLKx8),
    .RESET_N   (RESET_N),
    .fill      (w_fetch_done),
    .fill_ok   (w_fill_ok),
    .fill_tag  (r_mem_ad),
    .fill_data (MEM_RD),
    .inval     (w_dl_accept),
    .inval_tag (DL_AD[AW-1:1]),
    .look_tag  (SPR_AD[AW-1:1]),
    .hit       (w_hit),
    .line_data (w_line_data)
  );
`else
  assign w_hit       = 1'b0;
  assign w_line_data = '0;
`endif

  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_spr_ack    = 1'b0;
    w_go_hit     = 1'b0;
    w_go_fetch   = 1'b0;
    w_go_write   = 1'b0;
    w_fetch_done = 1'b0;
    w_write_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dl_pend) begin
          w_go_write  = 1'b1;
          w_state_nxt = ST_WRITE;
        end else if (SPR_REQ) begin
          if (w_hit) begin
            w_go_hit    = 1'b1;
            w_state_nxt = ST_HIT;
          end else begin
            w_go_fetch  = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HIT: begin
        w_spr_ack   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (MEM_ACK) begin
          w_fetch_done = 1'b1;
          w_state_nxt  = ST_RESP;
        end
      end
      ST_RESP: begin
        // A renderer that gave up during the fetch gets no acknowledge.
        w_spr_ack   = SPR_REQ;
        w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (MEM_ACK) begin
          w_write_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory-side command and renderer data registers. Command fields are
  // loaded together with MEM_REQ so they stay stable for the whole request.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dl_busy    <= 1'b0;
      r_dl_ad      <= '0;
      r_dl_dt      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_ad     <= '0;
      r_mem_wd     <= '0;
      r_mem_be     <= '0;
      r_fetch_lane <= C_LANE_LO;
      r_spr_dt     <= '0;
    end else begin
      if (w_dl_accept) begin
        r_dl_busy <= 1'b1;
        r_dl_ad   <= DL_AD;
        r_dl_dt   <= DL_DT;
      end else if (w_write_done) begin
        r_dl_busy <= 1'b0;
      end

      if (w_go_write) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= 1'b1;
        r_mem_ad  <= w_dl_pend_ad[AW-1:1];
        r_mem_wd  <= {w_dl_pend_dt, w_dl_pend_dt};
        r_mem_be  <= (w_dl_pend_ad[0] == C_LANE_HI) ? C_BE_HI : C_BE_LO;
      end else if (w_go_fetch) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_ad     <= SPR_AD[AW-1:1];
        r_mem_be     <= C_BE_WORD;
        r_fetch_lane <= SPR_AD[0];
      end else if (w_fetch_done || w_write_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end

      if (w_go_hit) begin
        r_spr_dt <= sel_byte(w_line_data, SPR_AD[0]);
      end else if (w_fetch_done) begin
        r_spr_dt <= sel_byte(MEM_RD, r_fetch_lane);
      end
    end
  end

  assign SPR_ACK = w_spr_ack;
  assign SPR_DT  = r_spr_dt;
  assign DL_BUSY = r_dl_busy;
  assign MEM_REQ = r_mem_req;
  assign MEM_WE  = r_mem_we;
  assign MEM_AD  = r_mem_ad;
  assign MEM_WD  = r_mem_wd;
  assign MEM_BE  = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_segasys1_sprrom_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_segasys1_sprrom_ctrl                                       |
// | Purpose  : Self-checking bench for segasys1_sprrom_ctrl. A behavioural   |
// |            pattern memory answers MEM_REQ after a fixed latency; read    |
// |            bytes expected by the renderer are queued from a byte-level   |
// |            shadow of the ROM and compared when SPR_ACK fires.            |
// | Config   : follows SEGASYS1_SPRROM_CACHE_EN like the design.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_segasys1_sprrom_ctrl;

  localparam int AW  = 18;
  localparam int LAT = 3;
`ifdef SEGASYS1_SPRROM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = LAT + 2;

  logic          VCLKx8;
  logic          RESET_N;
  logic          SPR_REQ;
  logic [AW-1:0] SPR_AD;
  logic          SPR_ACK;
  logic [7:0]    SPR_DT;
  logic          DL_WR;
  logic [AW-1:0] DL_AD;
  logic [7:0]    DL_DT;
  logic          DL_BUSY;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-2:0] MEM_AD;
  logic [15:0]   MEM_WD;
  logic [1:0]    MEM_BE;
  logic          MEM_ACK;
  logic [15:0]   MEM_RD;

  segasys1_sprrom_ctrl #(.AW(AW)) dut (
    .VCLKx8  (VCLKx8),
    .RESET_N (RESET_N),
    .SPR_REQ (SPR_REQ),
    .SPR_AD  (SPR_AD),
    .SPR_ACK (SPR_ACK),
    .SPR_DT  (SPR_DT),
    .DL_WR   (DL_WR),
    .DL_AD   (DL_AD),
    .DL_DT   (DL_DT),
    .DL_BUSY (DL_BUSY),
    .MEM_REQ (MEM_REQ),
    .MEM_WE  (MEM_WE),
    .MEM_AD  (MEM_AD),
    .MEM_WD  (MEM_WD),
    .MEM_BE  (MEM_BE),
    .MEM_ACK (MEM_ACK),
    .MEM_RD  (MEM_RD)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bit          tx_we[$];
  int          n_rd = 0;
  int          n_wr = 0;
  logic [16:0] last_rd_ad, last_wr_ad;
  logic [1:0]  last_rd_be, last_wr_be;
  logic [15:0] last_wr_wd;
  logic        rd_start_busy;
  logic [15:0] mem[0:511];
  logic [7:0]  sh[0:1023];

  initial begin
    VCLKx8 = 1'b0;
    forever #5 VCLKx8 = ~VCLKx8;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every acknowledged byte must match the oldest expectation.
  always @(negedge VCLKx8) begin
    if (RESET_N === 1'b1 && SPR_ACK === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_ack", 32'(SPR_ACK), 32'd0);
      else chk("spr_dt", 32'(SPR_DT), 32'(exp_q.pop_front()));
    end
  end

  // Pattern memory model: acknowledges on the LAT-th cycle of a request.
  initial begin
    int   cnt;
    logic sb;
    cnt = 0;
    sb = 1'b0;
    MEM_ACK = 1'b0;
    MEM_RD = 16'h0000;
    forever begin
      @(negedge VCLKx8);
      MEM_ACK = 1'b0;
      if (RESET_N !== 1'b1 || MEM_REQ !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt == 0) sb = DL_BUSY;
        cnt++;
        if (cnt == LAT) begin
          MEM_ACK = 1'b1;
          tx_we.push_back(MEM_WE);
          if (MEM_WE) begin
            if (MEM_BE[0]) mem[MEM_AD[8:0]][7:0]  = MEM_WD[7:0];
            if (MEM_BE[1]) mem[MEM_AD[8:0]][15:8] = MEM_WD[15:8];
            n_wr++;
            last_wr_ad = MEM_AD;
            last_wr_be = MEM_BE;
            last_wr_wd = MEM_WD;
          end else begin
            MEM_RD = mem[MEM_AD[8:0]];
            n_rd++;
            last_rd_ad = MEM_AD;
            last_rd_be = MEM_BE;
            rd_start_busy = sb;
          end
        end
      end
    end
  end

  task automatic rd(input logic [AW-1:0] a, input string tag, output int lat);
    int n;
    @(posedge VCLKx8); #1;
    SPR_AD = a;
    SPR_REQ = 1'b1;
    exp_q.push_back(sh[a[9:0]]);
    n = 0;
    lat = -1;
    while (n < 60) begin
      @(negedge VCLKx8);
      n++;
      if (SPR_ACK === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk({"timeout_", tag}, 32'd0, 32'd1);
    @(posedge VCLKx8); #1;
    SPR_REQ = 1'b0;
  endtask

  task automatic dl_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(posedge VCLKx8); #1;
    DL_WR = 1'b1;
    DL_AD = a;
    DL_DT = d;
    sh[a[9:0]] = d;
    @(posedge VCLKx8); #1;
    DL_WR = 1'b0;
  endtask

  task automatic wait_dl_idle(input string tag);
    int n;
    n = 0;
    while (DL_BUSY !== 1'b0 && n < 60) begin
      @(negedge VCLKx8);
      n++;
    end
    if (DL_BUSY !== 1'b0) chk({"busy_timeout_", tag}, 32'(DL_BUSY), 32'd0);
  endtask

  initial begin
    int lat, nr0, n;
    for (int w = 0; w < 512; w++) begin
      mem[w] = (w == 8) ? 16'hBEEF : {8'(w) ^ 8'h5C, 8'(w) ^ 8'hC3};
      sh[2*w]   = mem[w][7:0];
      sh[2*w+1] = mem[w][15:8];
    end
    RESET_N = 1'b0;
    SPR_REQ = 1'b0;
    SPR_AD  = '0;
    DL_WR   = 1'b0;
    DL_AD   = '0;
    DL_DT   = '0;

    // Reset state
    repeat (3) @(negedge VCLKx8);
    chk("rst_spr_ack", 32'(SPR_ACK), 32'd0);
    chk("rst_spr_dt",  32'(SPR_DT),  32'd0);
    chk("rst_dl_busy", 32'(DL_BUSY), 32'd0);
    chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("rst_mem_we",  32'(MEM_WE),  32'd0);
    chk("rst_mem_ad",  32'(MEM_AD),  32'd0);
    chk("rst_mem_wd",  32'(MEM_WD),  32'd0);
    chk("rst_mem_be",  32'(MEM_BE),  32'd0);
    @(posedge VCLKx8); #1;
    RESET_N = 1'b1;

    // Cold miss on byte 0x10 -> word 0x08, low lane of 0xBEEF
    nr0 = n_rd;
    rd(18'h00010, "t1", lat);
    chk("t1_latency", 32'(lat), 32'(MISS_LAT));
    chk("t1_reads", 32'(n_rd - nr0), 32'd1);
    chk("t1_mem_ad", 32'(last_rd_ad), 32'h8);
    chk("t1_mem_be", 32'(last_rd_be), 32'h3);

    // Odd byte of the same word: hit when cached, refetch otherwise
    nr0 = n_rd;
    rd(18'h00011, "t2", lat);
    chk("t2_latency", 32'(lat), 32'(CACHE ? HIT_LAT : MISS_LAT));
    chk("t2_reads", 32'(n_rd - nr0), 32'(CACHE ? 0 : 1));

    // Download write into the cached word, then the refetch it forces
    dl_wr(18'h00011, 8'h5A);
    chk("t3_busy_set", 32'(DL_BUSY), 32'd1);
    wait_dl_idle("t3");
    chk("t3_wr_ad", 32'(last_wr_ad), 32'h8);
    chk("t3_wr_be", 32'(last_wr_be), 32'h2);
    chk("t3_wr_wd", 32'(last_wr_wd), 32'h5A5A);
    nr0 = n_rd;
    rd(18'h00011, "t3rd", lat);
    chk("t3_latency", 32'(lat), 32'(MISS_LAT));
    chk("t3_reads", 32'(n_rd - nr0), 32'd1);

    // Download and read in the same IDLE cycle: write goes first
    tx_we.delete();
    fork
      dl_wr(18'h00020, 8'h33);
      rd(18'h00031, "t4", lat);
    join
    chk("t4_latency", 32'(lat), 32'(2 * LAT + 3));
    chk("t4_tx_count", 32'(tx_we.size()), 32'd2);
    if (tx_we.size() == 2) begin
      chk("t4_first_is_write", 32'(tx_we[0]), 32'd1);
      chk("t4_second_is_read", 32'(tx_we[1]), 32'd0);
    end
    chk("t4_busy_at_read", 32'(rd_start_busy), 32'd0);

    // Renderer gives up during the fetch: no ack, line still fills
    nr0 = n_rd;
    @(posedge VCLKx8); #1;
    SPR_AD = 18'h00041;
    SPR_REQ = 1'b1;
    n = 0;
    while (MEM_REQ !== 1'b1 && n < 20) begin @(negedge VCLKx8); n++; end
    chk("t5_fetch_started", 32'(MEM_REQ), 32'd1);
    @(posedge VCLKx8); #1;
    SPR_REQ = 1'b0;
    n = 0;
    while (MEM_REQ !== 1'b0 && n < 20) begin @(negedge VCLKx8); n++; end
    repeat (3) @(posedge VCLKx8);
    #1;
    chk("t5_dropped_reads", 32'(n_rd - nr0), 32'd1);
    nr0 = n_rd;
    rd(18'h00040, "t5", lat);
    chk("t5_latency", 32'(lat), 32'(CACHE ? HIT_LAT : MISS_LAT));
    chk("t5_reads", 32'(n_rd - nr0), 32'(CACHE ? 0 : 1));

    // Reset in the middle of a fetch with a download buffered
    nr0 = n_rd;
    @(posedge VCLKx8); #1;
    SPR_AD = 18'h00061;
    SPR_REQ = 1'b1;
    n = 0;
    while (MEM_REQ !== 1'b1 && n < 20) begin @(negedge VCLKx8); n++; end
    chk("t6_fetch_started", 32'(MEM_REQ), 32'd1);
    @(posedge VCLKx8); #1;
    DL_AD = 18'h00081;
    DL_DT = 8'h77;
    DL_WR = 1'b1;
    @(posedge VCLKx8); #1;
    DL_WR = 1'b0;
    chk("t6_busy_before_rst", 32'(DL_BUSY), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("t6_rst_dl_busy", 32'(DL_BUSY), 32'd0);
    chk("t6_rst_spr_ack", 32'(SPR_ACK), 32'd0);
    SPR_REQ = 1'b0;
    repeat (2) @(posedge VCLKx8);
    #1;
    RESET_N = 1'b1;
    chk("t6_abandoned_reads", 32'(n_rd - nr0), 32'd0);
    // Word 0x20 was resident before reset; it must now miss.
    nr0 = n_rd;
    rd(18'h00040, "t6", lat);
    chk("t6_latency", 32'(lat), 32'(MISS_LAT));
    chk("t6_reads", 32'(n_rd - nr0), 32'd1);

    repeat (4) @(posedge VCLKx8);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segasys1_sprrom_ctrl.md
# segasys1_sprrom_ctrl

Fetch controller and arbiter for the sprite pattern ROM. It sits between the sprite renderer's byte-wide ROM port (18-bit byte address, 8-bit data) and the external 16-bit pattern memory (SDRAM client port). It shares that memory between the renderer and the ROM download writer, and replaces fixed wait counting in the renderer with an explicit request/acknowledge handshake. An optional single-word line cache serves both bytes of a 16-bit word from one memory access.

## Interface
Parameters:
- AW, 18, byte address width; word address width is AW-1

Ports:
- VCLKx8  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- SPR_REQ  in  1  renderer read request; level, held with SPR_AD stable until SPR_ACK
- SPR_AD  in  AW  renderer byte address
- SPR_ACK  out  1  one-cycle pulse; SPR_DT valid in the same cycle
- SPR_DT  out  8  read byte; holds its value until the next SPR_ACK
- DL_WR  in  1  download byte write strobe; one cycle; legal only while DL_BUSY=0
- DL_AD  in  AW  download byte address
- DL_DT  in  8  download byte
- DL_BUSY  out  1  download buffer occupied
- MEM_REQ  out  1  memory request; level, held until MEM_ACK
- MEM_WE  out  1  1 = write, 0 = read
- MEM_AD  out  AW-1  word address
- MEM_WD  out  16  write data; the byte is replicated on both lanes
- MEM_BE  out  2  byte enables; writes: bit0 = low lane for even address, bit1 = high lane for odd address; reads: 2'b11
- MEM_ACK  in  1  one-cycle completion pulse; MEM_RD valid in the same cycle
- MEM_RD  in  16  read word

## Operation
- Byte order is little-endian: even byte address maps to MEM_RD[7:0], odd byte address maps to MEM_RD[15:8].
- FSM states:
  - IDLE: when a download write is pending, go to WRITE (download has priority). Otherwise, when SPR_REQ=1: on a cache hit go to HIT; on a miss latch the word address and go to FETCH.
  - HIT: pulse SPR_ACK with the selected byte from the line, then return to IDLE.
  - FETCH: drive MEM_REQ=1, MEM_WE=0. On MEM_ACK, load the line (tag = word address, valid = 1), capture SPR_DT and go to RESP.
  - RESP: pulse SPR_ACK only if SPR_REQ is still 1, then return to IDLE.
  - WRITE: drive MEM_REQ=1, MEM_WE=1. On MEM_ACK, clear the buffer and return to IDLE.
- Download buffer is one entry. DL_WR captures address and data and sets DL_BUSY; DL_BUSY clears in the cycle after MEM_ACK of the write. DL_WR while DL_BUSY=1 is a protocol violation and the write is dropped.
- Coherency: a download write whose word address equals the line tag clears valid at capture time.
- SPR_REQ dropped during FETCH: the fetch completes and the line fills; no SPR_ACK is generated.
- A new SPR_REQ with a different address is sampled only in IDLE.
- Reset values: SPR_ACK=0, SPR_DT=0, DL_BUSY=0, MEM_REQ=0, MEM_WE=0, MEM_AD=0, MEM_WD=0, MEM_BE=0, line valid=0, state=IDLE.
- Reset mid-transaction abandons the request. The memory side must drop an outstanding request when MEM_REQ falls.

## Timing
- Hit latency: SPR_REQ sampled at edge N gives SPR_ACK at N+1; one renderer byte per 2 cycles sustained.
- Miss: MEM_REQ rises at N+1. With MEM_ACK at cycle M, SPR_ACK occurs at M+1.
- Download arrival vs. SPR_REQ in the same IDLE cycle: the download is served first. The renderer waits one full write transaction plus one cycle.
- MEM_AD, MEM_WE, MEM_WD and MEM_BE are registered and stable for the whole MEM_REQ interval.
- MEM_REQ deasserts in the cycle after MEM_ACK; back-to-back requests have at least one idle cycle between them.

## Configuration
- SEGASYS1_SPRROM_CACHE_EN defined: single-word line cache is active as described.
- SEGASYS1_SPRROM_CACHE_EN undefined: no tag/valid storage exist; every SPR_REQ goes through FETCH and HIT is unreachable. Handshake and timing otherwise are unchanged.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, HIT, FETCH, RESP, WRITE)
  - AW default
  - byte-lane select helper constants
- One sub-module: segasys1_sprrom_line (tag, valid, 16-bit data, hit compare, invalidate port). It is instantiated only under SEGASYS1_SPRROM_CACHE_EN.

## Test plan
- Reset release; SPR_REQ with SPR_AD=0x00010; memory returns 0xBEEF after 3 cycles. Expect MEM_AD=0x00008, SPR_DT=0xEF, SPR_ACK one cycle after MEM_ACK.
- Follow-up SPR_AD=0x00011. Expect no MEM_REQ, SPR_ACK next cycle, SPR_DT=0xBE. With the macro undefined, a second fetch is required instead.
- DL_WR to 0x00011 with data 0x5A while the line holds word 0x00008. Expect MEM_WE=1, MEM_BE=2'b10, MEM_WD=0x5A5A. The next read of 0x00011 refetches.
- DL_WR and SPR_REQ asserted in the same cycle. Expect the write transaction first, then the read; DL_BUSY falls before the read MEM_REQ.
- SPR_REQ dropped mid-FETCH. Expect no SPR_ACK; the line fills, and the next request to the same word hits.
- RESET_N asserted during FETCH. Expect MEM_REQ=0 and DL_BUSY=0 immediately, and a miss on the next request.
